// File: rtl/right_rotator_32.sv
// Registered 32-bit right rotator (log-shifter: 1/2/4/8/16) with a valid tag, used for SHA-256 ROTR.
// Latency 1 clock (2 with RR_STAGE_PIPE_EN: extra register between the 4- and 8-rotate stages); no backpressure.
module right_rotator_32 #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [AMT_W-1:0] rotate_amt,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int SPLIT = 3;

    function automatic logic [WIDTH-1:0] rotr_pow2(input logic [WIDTH-1:0] x, input int s);
        return (x >> (1 << s)) | (x << (WIDTH - (1 << s)));
    endfunction

    logic [WIDTH-1:0]       lo_stg [0:SPLIT];
    logic [WIDTH-1:0]       hi_stg [SPLIT:AMT_W];
    logic [WIDTH-1:0]       mid_dat;
    logic [AMT_W-1:SPLIT]   mid_amt;
    logic                   mid_vld;
    logic [WIDTH-1:0]       out_d, out_q;
    logic                   out_valid_d, out_valid_q;

    always_comb begin
        lo_stg[0] = in;
        for (int s = 0; s < SPLIT; s++) begin
            lo_stg[s+1] = rotate_amt[s] ? rotr_pow2(lo_stg[s], s) : lo_stg[s];
        end
    end

`ifdef RR_STAGE_PIPE_EN
    logic [WIDTH-1:0]     mid_dat_d, mid_dat_q;
    logic [AMT_W-1:SPLIT] mid_amt_d, mid_amt_q;
    logic                 mid_vld_d, mid_vld_q;

    always_comb begin
        mid_vld_d = in_valid;
        mid_dat_d = mid_dat_q;
        mid_amt_d = mid_amt_q;
        if (in_valid) begin
            mid_dat_d = lo_stg[SPLIT];
            mid_amt_d = rotate_amt[AMT_W-1:SPLIT];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mid_dat_q <= '0;
            mid_amt_q <= '0;
            mid_vld_q <= 1'b0;
        end else begin
            mid_dat_q <= mid_dat_d;
            mid_amt_q <= mid_amt_d;
            mid_vld_q <= mid_vld_d;
        end
    end

    assign mid_dat = mid_dat_q;
    assign mid_amt = mid_amt_q;
    assign mid_vld = mid_vld_q;
`else
    assign mid_dat = lo_stg[SPLIT];
    assign mid_amt = rotate_amt[AMT_W-1:SPLIT];
    assign mid_vld = in_valid;
`endif

    always_comb begin
        hi_stg[SPLIT] = mid_dat;
        for (int s = SPLIT; s < AMT_W; s++) begin
            hi_stg[s+1] = mid_amt[s] ? rotr_pow2(hi_stg[s], s) : hi_stg[s];
        end
    end

    // Result register holds its value across idle cycles.
    always_comb begin
        out_valid_d = mid_vld;
        out_d       = mid_vld ? hi_stg[AMT_W] : out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_right_rotator_32.sv
// Directed bench for right_rotator_32: reset, hand-computed vectors, gap/hold, in-flight reset, 256x32 sweep.
module tb_right_rotator_32;

`ifdef RR_STAGE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in;
    logic [4:0]  rotate_amt;
    logic [31:0] out;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    logic        mv1 = 1'b0, mv2 = 1'b0;
    logic [31:0] md1 = '0, md2 = '0;
    logic [31:0] got [$];
    logic [31:0] exp_out;
    logic        exp_vld;

    right_rotator_32 dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in         (in),
        .rotate_amt (rotate_amt),
        .out        (out),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_rot(input logic [31:0] x, input int a);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = x[(k + a) % 32];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive, advance the reference pipeline, compare just after the edge.
    task automatic cycle(input logic rst, input logic vld, input logic [31:0] d, input int a);
        reset      = rst;
        in_valid   = vld;
        in         = d;
        rotate_amt = a[4:0];
        @(posedge clk);
        if (rst) begin
            mv1 = 1'b0; mv2 = 1'b0; md1 = '0; md2 = '0;
        end else begin
            mv2 = mv1;
            if (mv1) md2 = md1;
            mv1 = vld;
            if (LAT == 1) begin
                if (vld) md1 = ref_rot(d, a);
            end else begin
                if (vld) md1 = ref_rot(d, a);
            end
        end
        exp_vld = (LAT == 1) ? mv1 : mv2;
        exp_out = (LAT == 1) ? md1 : md2;
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_vld});
        chk("out", out, exp_out);
        if (out_valid) got.push_back(out);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in = '0; rotate_amt = '0;

        // Reset wins over a simultaneous valid operand.
        cycle(1, 1, 32'hFFFF_FFFF, 0);
        chk("rst_out", out, 32'h0);
        chk("rst_vld", {31'b0, out_valid}, 32'h0);
        cycle(1, 1, 32'hFFFF_FFFF, 5);
        cycle(0, 0, 32'h0, 0);
        chk("post_rst_out", out, 32'h0);
        chk("post_rst_vld", {31'b0, out_valid}, 32'h0);

        // Back-to-back A5 vectors.
        got.delete();
        cycle(0, 1, 32'h0000_00A5, 0);
        cycle(0, 1, 32'h0000_00A5, 1);
        cycle(0, 1, 32'h0000_00A5, 4);
        cycle(0, 1, 32'h0000_00A5, 31);
        for (int i = 0; i < LAT; i++) cycle(0, 0, 32'h0, 0);
        chk("a5_count", got.size(), 32'd4);
        if (got.size() == 4) begin
            chk("a5_r0",  got[0], 32'h0000_00A5);
            chk("a5_r1",  got[1], 32'h8000_0052);
            chk("a5_r4",  got[2], 32'h5000_000A);
            chk("a5_r31", got[3], 32'h0000_014A);
        end

        // Wrap across the byte and half-word stages.
        got.delete();
        cycle(0, 1, 32'h8000_0001, 8);
        cycle(0, 1, 32'h8000_0001, 16);
        for (int i = 0; i < LAT; i++) cycle(0, 0, 32'h0, 0);
        chk("wrap_count", got.size(), 32'd2);
        if (got.size() == 2) begin
            chk("wrap_r8",  got[0], 32'h0180_0000);
            chk("wrap_r16", got[1], 32'h0001_8000);
        end

        // One operand then a 3-cycle gap: single pulse, output holds.
        got.delete();
        cycle(0, 1, 32'h1234_5678, 4);
        for (int i = 0; i < 3; i++) cycle(0, 0, 32'hDEAD_BEEF, 13);
        chk("gap_pulses", got.size(), 32'd1);
        chk("gap_hold", out, 32'h8123_4567);
        chk("gap_vld", {31'b0, out_valid}, 32'h0);

        // Reset while operands are in flight: nothing emerges afterwards.
        cycle(0, 1, 32'hCAFE_F00D, 3);
        cycle(1, 1, 32'h0BAD_F00D, 7);
        got.delete();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 32'h0, 0);
            chk("flush_vld", {31'b0, out_valid}, 32'h0);
            chk("flush_out", out, 32'h0);
        end
        chk("flush_count", got.size(), 32'd0);

        // Sweep every amount over the first 256 operands.
        for (int v = 0; v < 256; v++) begin
            for (int a = 0; a < 32; a++) begin
                cycle(0, 1, 32'(v), a);
                chk("sweep_lo", {24'b0, out[7:0]}, {24'b0, exp_out[7:0]});
            end
        end
        for (int i = 0; i < LAT; i++) cycle(0, 0, 32'h0, 0);
        chk("sweep_last", out, ref_rot(32'd255, 31));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/right_rotator_32.md
Name: right_rotator_32

Overview:
- Registered 32-bit right-rotate (barrel rotator) for the SHA-256 ALU; serves the ROTR operations in the Σ/σ functions.
- Takes an operand and a 5-bit rotate amount and returns the operand rotated right by that amount. Bits leaving bit 0 re-enter at bit 31.
- Implemented as a 5-stage logarithmic mux network (shifts of 1/2/4/8/16) with a registered output and a valid tag.

Parameters:
- WIDTH, 32, operand width; must be a power of two; only 32 is verified.
- AMT_W, 5, rotate-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in/rotate_amt this cycle.
- in  input  WIDTH  operand to rotate.
- rotate_amt  input  AMT_W  right-rotate distance, 0..31, unsigned.
- out  output  WIDTH  rotated result.
- out_valid  output  1  out holds the result of a valid input.

Behaviour:
- Function: out = (in >> rotate_amt) | (in << (WIDTH - rotate_amt)), modulo WIDTH. Equivalently, out[k] = in[(k + rotate_amt) mod 32].
- Structure: stage s (s = 0..4) rotates right by 2^s when rotate_amt[s] = 1, and passes its input through otherwise. Stages are applied in order 1, 2, 4, 8, 16.
- Latency: 1 clock. Inputs sampled at edge N appear on out/out_valid after edge N.
- No backpressure: a new operand is accepted every cycle. Throughput is 1 per clock.
- out_valid: registered copy of in_valid.
- out updates only when in_valid = 1 and holds its previous value otherwise. Consumers must use out only when out_valid = 1.
- rotate_amt = 0 gives out = in, identity with no bit movement.
- rotate_amt = 31 is equivalent to rotate-left by 1.
- No inputs are out of range: every 5-bit value is legal, so wrap-around is inherent.
- Reset (synchronous, active-high): out = 0 and out_valid = 0 on the first edge with reset = 1.
  - Reset has priority over a simultaneous in_valid; that input is discarded.
  - Any in-flight result is dropped; no output appears for it after reset.
- After reset deasserts, the first in_valid = 1 cycle produces a result on the following edge.
- Purely datapath: no FSM, no X propagation from unused paths. All mux selects come only from rotate_amt.

Optional Feature:
- Macro: RR_STAGE_PIPE_EN.
- When defined:
  - An additional register sits between the 4-stage and 8-stage rotations. The intermediate data, rotate_amt[4:3] and the valid bit are all registered.
  - Latency becomes 2 clocks and throughput stays 1 per clock.
  - Reset clears the intermediate valid and data to 0.
  - Reset mid-operation discards both in-flight operands.
- When undefined: single registered output, latency 1, as above.
- Function is identical in both builds; only the out_valid timing differs.

Test Plan:
- Reset with in_valid = 1, in = 0xFFFFFFFF -> out = 0x00000000, out_valid = 0 during and on the first cycle after reset.
- in = 0x000000A5, rotate_amt = 0, 1, 4, 31 back-to-back with in_valid = 1 -> out = 0x000000A5, 0x80000052, 0x5000000A, 0x0000014A on consecutive cycles, each with out_valid = 1.
- in = 0x80000001, rotate_amt = 8 -> out = 0x01800000. Then rotate_amt = 16 -> 0x00018000.
- Exhaustive sweep: in = 0..255 combined with every rotate_amt 0..31 -> out matches the reference rotate. Also check out[7:0] against the same 8-bit slice.
- Gap in stream: valid operand, then in_valid = 0 for 3 cycles -> out_valid pulses once and out holds the last result during the gap.
- With RR_STAGE_PIPE_EN: same vectors -> identical values delayed by 2 cycles. Assert reset while two operands are in flight -> neither result appears and out_valid stays 0.
